// File: rtl/wave_pkg.sv
// Shared constants for the wave-profile engine: frequency step table, FSM states, LUT magnitude width.
package wave_pkg;

    localparam int unsigned NUM_FREQ = 25;
    localparam int unsigned MAG_W    = 10;
    localparam int unsigned STEP_W   = 16;

    // Q8.8 phase steps, 64 + 32*k; k = 6 sweeps exactly one sine period over 1024 entries
    localparam logic [STEP_W-1:0] FREQ_STEP [0:NUM_FREQ-1] = '{
        16'd64,  16'd96,  16'd128, 16'd160, 16'd192, 16'd224, 16'd256,
        16'd288, 16'd320, 16'd352, 16'd384, 16'd416, 16'd448, 16'd480,
        16'd512, 16'd544, 16'd576, 16'd608, 16'd640, 16'd672, 16'd704,
        16'd736, 16'd768, 16'd800, 16'd832
    };

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FILL  = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } wave_state_t;

    function automatic logic [4:0] clamp_freq(input logic [4:0] id);
        return (id > 5'(NUM_FREQ - 1)) ? 5'(NUM_FREQ - 1) : id;
    endfunction

endpackage

// File: rtl/wave_sine_lut.sv
// Registered half-wave sine magnitude source: addr MSB is the sign, lower bits index the half period.
module wave_sine_lut
    import wave_pkg::*;
#(
    parameter int unsigned LOG_SINE = 10
)(
    input  logic                clock,
    input  logic [LOG_SINE-1:0] addr,
    output logic                sign,
    output logic [MAG_W-1:0]    mag
);

    localparam int unsigned HALF_W = LOG_SINE - 1;
    localparam int unsigned NORM   = 2 * LOG_SINE - 4;   // log2 of the peak of pos*(half-pos)
    localparam int unsigned P_W    = NORM + 1;
    localparam int unsigned A_W    = P_W + 10;
    localparam int unsigned S_W    = P_W + MAG_W;

    logic [HALF_W-1:0] pos;
    logic [HALF_W:0]   rest;
    logic [P_W-1:0]    para;
    logic [2*P_W-1:0]  para_sq_full;
    logic [P_W-1:0]    para_sq;
    logic [A_W-1:0]    blend_full;
    logic [P_W-1:0]    blend;
    logic [S_W-1:0]    scaled;
    logic [MAG_W-1:0]  mag_next;

    // sin(pi*x) ~= 0.775*p + 0.225*p^2 with p = 4x(1-x); exact at 0 and at the quarter point
    always_comb begin
        pos          = addr[HALF_W-1:0];
        rest         = (HALF_W+1)'(1 << HALF_W) - (HALF_W+1)'(pos);
        para         = P_W'(pos) * P_W'(rest);
        para_sq_full = (2*P_W)'(para) * (2*P_W)'(para);
        para_sq      = P_W'(para_sq_full >> NORM);
        blend_full   = A_W'(para) * A_W'(794) + A_W'(para_sq) * A_W'(230);
        blend        = P_W'(blend_full >> 10);
        scaled       = S_W'(blend) * S_W'((1 << MAG_W) - 1);
        mag_next     = MAG_W'(scaled >> NORM);
    end

    always_ff @(posedge clock) begin
        sign <= addr[LOG_SINE-1];
        mag  <= mag_next;
    end

endmodule

// File: rtl/wave_profile_gen.sv
// Wave-profile engine: fills a height table from the sine LUT on request; registered read port.
// Define WAVE_DOUBLE_BUFFER_EN for two banks with a swap on completion.
module wave_profile_gen
    import wave_pkg::*;
#(
    parameter int unsigned LOG_WIDTH = 10,
    parameter int unsigned WIDTH     = 1024,
    parameter int unsigned H_W       = 10,
    parameter int unsigned LOG_SINE  = 10,
    parameter int unsigned FRAC_W    = 8,
    parameter int unsigned OFFSET    = 384
)(
    input  logic                 clock,
    input  logic                 reset,
    input  logic [4:0]           freq_id,
    input  logic [1:0]           amp_shift,
    input  logic                 new_f,
    input  logic [LOG_WIDTH-1:0] index,
    output logic [H_W-1:0]       wave_height,
    output logic                 wave_ready,
    output logic                 busy
);

    localparam int unsigned PH_W  = FRAC_W + LOG_SINE;
    localparam int          H_MAX = (1 << H_W) - 1;

    wave_state_t          state;
    logic [STEP_W-1:0]    step;
    logic [1:0]           shift;
    logic [PH_W-1:0]      phase;
    logic [LOG_WIDTH-1:0] cnt;
    logic                 wr_en;
    logic [LOG_WIDTH-1:0] wr_addr;
    logic                 lut_sign;
    logic [MAG_W-1:0]     lut_mag;
    logic [MAG_W-1:0]     attn;
    int                   level;
    logic [H_W-1:0]       sample;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else if (new_f) begin
            state <= LOAD;
        end else begin
            case (state)
                LOAD:    state <= FILL;
                FILL:    state <= (cnt == LOG_WIDTH'(WIDTH - 1)) ? FLUSH : FILL;
                FLUSH:   state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            step  <= '0;
            shift <= '0;
            phase <= '0;
            cnt   <= '0;
        end else begin
            if (new_f) begin
                step  <= FREQ_STEP[clamp_freq(freq_id)];
                shift <= amp_shift;
            end
            if (state == LOAD) begin
                phase <= '0;
                cnt   <= '0;
            end else if (state == FILL) begin
                phase <= phase + PH_W'(step);
                cnt   <= cnt + 1'b1;
            end
        end
    end

    // LUT result lands one cycle after issue, so the write address trails the count by one
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
        end else begin
            wr_en   <= (state == FILL);
            wr_addr <= cnt;
        end
    end

    wave_sine_lut #(
        .LOG_SINE (LOG_SINE)
    ) u_lut (
        .clock (clock),
        .addr  (phase[PH_W-1:FRAC_W]),
        .sign  (lut_sign),
        .mag   (lut_mag)
    );

    always_comb begin
        attn  = lut_mag >> (3'd2 + {1'b0, shift});
        level = lut_sign ? (int'(OFFSET) - int'(attn)) : (int'(OFFSET) + int'(attn));
        if (level < 0) begin
            sample = '0;
        end else if (level > H_MAX) begin
            sample = '1;
        end else begin
            sample = H_W'(level);
        end
    end

`ifdef WAVE_DOUBLE_BUFFER_EN
    logic                 bank_sel;
    logic [H_W-1:0]       table_ram [0:2*WIDTH-1];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            table_ram[{~bank_sel, wr_addr}] <= sample;
        end
    end

    // only a completed fill reaches DONE, so an aborted fill never swaps
    always_ff @(posedge clock) begin
        if (reset) begin
            bank_sel <= 1'b0;
        end else if (state == DONE) begin
            bank_sel <= ~bank_sel;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wave_height <= '0;
        end else begin
            wave_height <= table_ram[{bank_sel, index}];
        end
    end
`else
    logic [H_W-1:0]       table_ram [0:WIDTH-1];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            table_ram[wr_addr] <= sample;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wave_height <= '0;
        end else begin
            wave_height <= table_ram[index];
        end
    end
`endif

    assign wave_ready = (state == DONE);
    assign busy       = (state == LOAD) || (state == FILL) || (state == FLUSH);

endmodule

// File: tb/tb_wave_profile_gen.sv
// Directed self-checking bench for wave_profile_gen; sample points chosen where the LUT address is exact.
module tb_wave_profile_gen;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] freq_id;
    logic [1:0] amp_shift;
    logic       new_f;
    logic [9:0] index;
    logic [9:0] wave_height;
    logic       wave_ready;
    logic       busy;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    wave_profile_gen dut (
        .clock       (clock),
        .reset       (reset),
        .freq_id     (freq_id),
        .amp_shift   (amp_shift),
        .new_f       (new_f),
        .index       (index),
        .wave_height (wave_height),
        .wave_ready  (wave_ready),
        .busy        (busy)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // request issued in cycle T; returns at the sample point of cycle T+1
    task automatic pulse(input logic [4:0] f, input logic [1:0] s);
        freq_id   = f;
        amp_shift = s;
        new_f     = 1'b1;
        @(negedge clock);
        new_f     = 1'b0;
    endtask

    task automatic watch(input int n, output int pulses, output int first_k);
        pulses  = 0;
        first_k = -1;
        for (int k = 1; k <= n; k++) begin
            if (k > 1) @(negedge clock);
            if (wave_ready) begin
                pulses++;
                if (first_k < 0) first_k = k;
            end
        end
    endtask

    task automatic run_fill(input logic [4:0] f, input logic [1:0] s, input string tag);
        int p;
        int k;
        pulse(f, s);
        check({tag, "_busy_load"}, int'(busy), 1);
        watch(1100, p, k);
        check({tag, "_ready_count"}, p, 1);
        check({tag, "_ready_cycle"}, k, 1027);
        check({tag, "_busy_idle"}, int'(busy), 0);
    endtask

    task automatic read_entry(input int idx, output int h);
        index = 10'(idx);
        @(negedge clock);
        h = int'(wave_height);
    endtask

    task automatic check_entry(input string tag, input int idx, input int exp);
        int h;
        read_entry(idx, h);
        check(tag, h, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int k;
        reset     = 1'b1;
        new_f     = 1'b0;
        freq_id   = '0;
        amp_shift = '0;
        index     = '0;
        repeat (2) @(negedge clock);
        check("reset_ready", int'(wave_ready), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_height", int'(wave_height), 0);
        reset = 1'b0;
        @(negedge clock);

        // one full period at freq 6, full amplitude
        run_fill(5'd6, 2'd0, "f6");
        check_entry("f6_h0", 0, 384);
        check_entry("f6_h256", 256, 639);
        check_entry("f6_h512", 512, 384);
        check_entry("f6_h768", 768, 129);

        // out-of-range id clamps to 24 (13/4 LUT points per entry)
        run_fill(5'd31, 2'd0, "f31");
        check_entry("f31_h0", 0, 384);
        check_entry("f31_h79", 79, 639);
        check_entry("f31_h394", 394, 639);
        check_entry("f31_h709", 709, 639);
        run_fill(5'd24, 2'd0, "f24");
        check_entry("f24_h79", 79, 639);
        check_entry("f24_h709", 709, 639);

        run_fill(5'd6, 2'd3, "f6a3");
        check_entry("f6a3_h256", 256, 415);
        check_entry("f6a3_h768", 768, 353);
        check_entry("f6a3_h512", 512, 384);

        // restart mid-fill: only the second request completes
        pulse(5'd6, 2'd0);
        watch(499, p, k);
        check("restart_no_early_ready", p, 0);
        pulse(5'd12, 2'd0);
        watch(1100, p, k);
        check("restart_ready_count", p, 1);
        check("restart_ready_cycle", k, 1027);
        check_entry("f12_h439", 439, 129);
        check_entry("f12_h293", 293, 384);

        // reset while cnt == 300
        pulse(5'd6, 2'd0);
        repeat (301) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort_busy", int'(busy), 0);
        check("abort_ready", int'(wave_ready), 0);
        reset = 1'b0;
        watch(1100, p, k);
        check("abort_no_ready", p, 0);
`ifdef WAVE_DOUBLE_BUFFER_EN
        check_entry("abort_bank0_h768", 768, 353);
`else
        check_entry("abort_partial_h256", 256, 639);
`endif
        run_fill(5'd12, 2'd0, "after_abort");
        check_entry("after_abort_h439", 439, 129);

        // refill while continuously reading entry 256
        run_fill(5'd6, 2'd0, "base6");
        index = 10'd256;
        @(negedge clock);
        check("refill_before", int'(wave_height), 639);
        pulse(5'd6, 2'd3);
`ifdef WAVE_DOUBLE_BUFFER_EN
        for (int c = 1; c <= 1030; c++) begin
            if (c > 1) @(negedge clock);
            if (c == 2 || c == 600 || c == 1026 || c == 1027 || c == 1028)
                check($sformatf("refill_old_c%0d", c), int'(wave_height), 639);
            if (c == 1027)
                check("refill_ready", int'(wave_ready), 1);
            if (c == 1029)
                check("refill_new", int'(wave_height), 415);
        end
`else
        watch(1100, p, k);
        check("refill_ready_cycle", k, 1027);
        check("refill_new", int'(wave_height), 415);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
